// File: rtl/cooler_pkg.sv
// Shared definitions for the cooler PWM driver: widths, FSM encoding and
// the duty clamp used when a period's accumulated correction is applied.
package cooler_pkg;

  localparam int PWM_W  = 8;   // PWM counter and duty width
  localparam int PEND_W = 9;   // signed pending-correction accumulator width
  localparam int MATH_W = 12;  // signed width for the duty update arithmetic

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RAMP = 2'b01;
  localparam state_t ST_RUN  = 2'b10;

  // Clamp a signed update result into the legal duty window [0, hi].
  function automatic logic [PWM_W-1:0] clamp_duty(input logic signed [MATH_W-1:0] v,
                                                  input logic [PWM_W-1:0]         hi);
    logic signed [MATH_W-1:0] hi_s;
    hi_s = $signed({{(MATH_W-PWM_W){1'b0}}, hi});
    if (v[MATH_W-1])
      return '0;
    else if (v > hi_s)
      return hi;
    else
      return v[PWM_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: a prescaler producing one count tick every PRESC clocks and
// an 8-bit PWM counter advanced on each tick. wrap marks the last tick of a
// PWM period, which is the only point where the applied duty may change.
module pwm_timebase
  import cooler_pkg::*;
#(
  parameter int PRESC = 78
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [PWM_W-1:0] pwm_cnt,
  output logic             tick,
  output logic             wrap
);

  localparam int             PS_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESC - 1);

  logic [PS_W-1:0] presc;

  assign tick = (presc == PS_LAST);
  assign wrap = tick && (pwm_cnt == '1);

  // Prescaler and PWM counter; clear holds both at zero so a new ramp starts on a clean period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (clear) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end else begin
      presc   <= presc + PS_W'(1);
    end
  end

endmodule

// File: rtl/cooler_pwm_driver.sv
// Cooler PWM driver: turns signed PID corrections into a glitch-free PWM
// drive. Corrections accumulate in a saturating pending register and are
// folded into the duty only at a period wrap. Enabling starts a soft-start
// ramp up to DUTY_INIT before closed-loop corrections are accepted.
module cooler_pwm_driver
  import cooler_pkg::*;
#(
  parameter int PRESC      = 78,
  parameter int DUTY_MAX   = 240,
  parameter int DUTY_INIT  = 64,
  parameter int STEP_SHIFT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic signed [3:0] du_reg,
  input  logic              du_valid,
  output logic              pwm_out,
  output logic [PWM_W-1:0]  duty,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic [1:0]        state
);

  generate
    if (DUTY_INIT > DUTY_MAX) begin : g_bad_duty_init
      $error("cooler_pwm_driver: DUTY_INIT must not exceed DUTY_MAX");
    end
    if (DUTY_MAX > 255) begin : g_bad_duty_max
      $error("cooler_pwm_driver: DUTY_MAX must fit in 8 bits");
    end
  endgenerate

  localparam logic [PWM_W-1:0]         DMAX8  = PWM_W'(DUTY_MAX);
  localparam logic [PWM_W-1:0]         DINIT8 = PWM_W'(DUTY_INIT);
  localparam logic signed [PEND_W:0]   P_MAX  = 10'sd255;
  localparam logic signed [PEND_W:0]   P_MIN  = -10'sd256;

  // Saturate the widened accumulator sum back into the pending range [-256, 255].
  function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [PEND_W:0] v);
    if (v > P_MAX)
      return 9'h0FF;
    else if (v < P_MIN)
      return 9'h100;
    else
      return v[PEND_W-1:0];
  endfunction

  logic [PWM_W-1:0]         duty_active;
  logic signed [PEND_W-1:0] pending;
  logic [PWM_W-1:0]         pwm_cnt;
  logic                     wrap;
  logic                     tick_unused;
  logic                     clear;

  logic signed [PEND_W:0]   pend_sum;
  logic signed [PEND_W-1:0] pend_next;
  logic signed [MATH_W-1:0] pend_ext;
  logic signed [MATH_W-1:0] duty_raw;
  logic signed [MATH_W-1:0] duty_max_s;
  logic [PWM_W-1:0]         duty_inc;

  // Counters run only while enabled and out of IDLE, so each ramp begins at count 0.
  assign clear = !enable || (state == ST_IDLE);

  pwm_timebase #(
    .PRESC (PRESC)
  ) u_timebase (
    .clk     (CLK),
    .rst     (RST),
    .clear   (clear),
    .pwm_cnt (pwm_cnt),
    .tick    (tick_unused),
    .wrap    (wrap)
  );

  // Next pending value (including a coincident strobe) and the candidate duty it would produce.
  always_comb begin
    pend_sum = {pending[PEND_W-1], pending};
    if (du_valid)
      pend_sum = pend_sum + $signed({{(PEND_W-3){du_reg[3]}}, du_reg});
    pend_next  = sat_pend(pend_sum);
    pend_ext   = {{(MATH_W-PEND_W){pend_next[PEND_W-1]}}, pend_next};
    duty_raw   = $signed({{(MATH_W-PWM_W){1'b0}}, duty_active}) + (pend_ext <<< STEP_SHIFT);
    duty_max_s = $signed({{(MATH_W-PWM_W){1'b0}}, DMAX8});
    duty_inc   = duty_active + PWM_W'(1);
  end

  // Mode FSM, pending accumulator and period-boundary duty update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      duty_active <= '0;
      pending     <= '0;
      sat_hi      <= 1'b0;
      sat_lo      <= 1'b0;
    end else if (!enable) begin
      state       <= ST_IDLE;
      duty_active <= '0;
      pending     <= '0;
      sat_hi      <= 1'b0;
      sat_lo      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= ST_RAMP;
          duty_active <= '0;
          pending     <= '0;
          sat_hi      <= 1'b0;
          sat_lo      <= 1'b0;
        end
        ST_RAMP: begin
          // Corrections are meaningless until the soft start finishes.
          pending <= '0;
          sat_hi  <= 1'b0;
          sat_lo  <= 1'b0;
          if (wrap) begin
            if (duty_active < DINIT8)
              duty_active <= duty_inc;
            if (duty_inc >= DINIT8)
              state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            duty_active <= clamp_duty(duty_raw, DMAX8);
            sat_hi      <= (duty_raw > duty_max_s);
            sat_lo      <= duty_raw[MATH_W-1];
            pending     <= '0;
          end else if (du_valid) begin
            pending <= pend_next;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered PWM compare; dropping enable forces the drive low on the very next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      pwm_out <= 1'b0;
    else
      pwm_out <= enable && (state != ST_IDLE) && (pwm_cnt < duty_active);
  end

  assign duty = duty_active;

endmodule

// File: tb/tb_cooler_pwm_driver.sv
// Directed bench for cooler_pwm_driver with PRESC=2, DUTY_INIT=4 (512-clock
// PWM period). A bench-side phase counter tracks the PWM period so that
// corrections can be placed at known positions relative to each wrap.
module tb_cooler_pwm_driver;

  logic              CLK = 1'b0;
  logic              RST;
  logic              enable;
  logic signed [3:0] du_reg;
  logic              du_valid;
  logic              pwm_out;
  logic [7:0]        duty;
  logic              sat_hi;
  logic              sat_lo;
  logic [1:0]        state;

  int n_chk = 0;
  int n_err = 0;
  int phase = 0;
  int highs;

  always #25 CLK = ~CLK;

  cooler_pwm_driver #(
    .PRESC      (2),
    .DUTY_MAX   (240),
    .DUTY_INIT  (4),
    .STEP_SHIFT (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .du_reg   (du_reg),
    .du_valid (du_valid),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .sat_hi   (sat_hi),
    .sat_lo   (sat_lo),
    .state    (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock; phase 0 is the negedge right after a wrap edge.
  task automatic tick1();
    @(negedge CLK);
    phase = (phase + 1) % 512;
  endtask

  task automatic next_wrap();
    do tick1(); while (phase != 0);
  endtask

  task automatic goto_phase(input int p);
    do tick1(); while (phase != p);
  endtask

  task automatic pulse(input int d);
    du_reg   = 4'(d);
    du_valid = 1'b1;
    tick1();
    du_valid = 1'b0;
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (512) begin
      tick1();
      if (pwm_out) n++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST      = 1'b1;
    enable   = 1'b0;
    du_reg   = 4'sd0;
    du_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_duty", duty, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);
    chk("rst_state", state, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_disabled", state, 0);

    // Soft-start ramp
    enable = 1'b1;
    @(negedge CLK);
    phase = 0;
    chk("ramp_enter", state, 1);
    chk("ramp_duty0", duty, 0);
    goto_phase(511);
    chk("ramp_prewrap", duty, 0);
    tick1();
    chk("ramp_w1", duty, 1);
    next_wrap();
    chk("ramp_w2", duty, 2);
    next_wrap();
    chk("ramp_w3", duty, 3);
    chk("ramp_w3_state", state, 1);
    next_wrap();
    chk("ramp_w4", duty, 4);
    chk("run_enter", state, 2);
    count_high(highs);
    chk("pwm_high_d4", highs, 8);
    chk("run_hold_d4", duty, 4);

    // Two corrections in one period
    pulse(3);
    pulse(2);
    next_wrap();
    chk("upd_d24", duty, 24);
    chk("upd_sat_hi", sat_hi, 0);
    chk("upd_sat_lo", sat_lo, 0);
    next_wrap();
    chk("pend_cleared", duty, 24);

    // Saturate high
    du_reg   = 4'sd7;
    du_valid = 1'b1;
    repeat (20) tick1();
    du_valid = 1'b0;
    next_wrap();
    chk("clamp_hi_duty", duty, 240);
    chk("clamp_hi_flag", sat_hi, 1);
    chk("clamp_hi_lo", sat_lo, 0);
    count_high(highs);
    chk("pwm_high_d240", highs, 480);
    chk("clamp_hi_hold", duty, 240);
    chk("sat_hi_cleared", sat_hi, 0);

    // Bring duty down to 8 (-58 << 2 = -232)
    du_reg   = -4'sd8;
    du_valid = 1'b1;
    repeat (7) tick1();
    du_reg   = -4'sd2;
    tick1();
    du_valid = 1'b0;
    next_wrap();
    chk("down_d8", duty, 8);
    chk("down_sat_hi", sat_hi, 0);

    // -8 arriving on the wrap cycle itself, clamps at 0
    goto_phase(511);
    du_reg   = -4'sd8;
    du_valid = 1'b1;
    tick1();
    du_valid = 1'b0;
    chk("clamp_lo_duty", duty, 0);
    chk("clamp_lo_flag", sat_lo, 1);
    chk("clamp_lo_hi", sat_hi, 0);
    count_high(highs);
    chk("pwm_high_d0", highs, 0);
    chk("sat_lo_cleared", sat_lo, 0);
    chk("clamp_lo_hold", duty, 0);

    // Enable drop mid-pulse, then restart
    pulse(4);
    next_wrap();
    chk("up_d16", duty, 16);
    goto_phase(10);
    chk("pulse_high", pwm_out, 1);
    enable = 1'b0;
    tick1();
    chk("dis_pwm", pwm_out, 0);
    chk("dis_state", state, 0);
    chk("dis_duty", duty, 0);
    enable = 1'b1;
    @(negedge CLK);
    phase = 0;
    chk("reramp_state", state, 1);
    chk("reramp_duty", duty, 0);
    pulse(7);
    next_wrap();
    chk("ramp_ignores_du", duty, 1);
    next_wrap();
    next_wrap();
    pulse(5);
    next_wrap();
    chk("reramp_d4", duty, 4);
    chk("reramp_run", state, 2);
    next_wrap();
    chk("ramp_pend_zero", duty, 4);

    // Asynchronous reset mid-RUN
    pulse(5);
    next_wrap();
    chk("run_d24", duty, 24);
    goto_phase(20);
    chk("pre_rst_pwm", pwm_out, 1);
    #5;
    RST = 1'b1;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_duty", duty, 0);
    chk("arst_state", state, 0);
    chk("arst_sat", {sat_hi, sat_lo}, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_ramp", state, 1);
    chk("post_rst_duty", duty, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
